// File: rtl/uart_pwm_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_pwm_cmd_ctrl
// Brief  : Host command controller: assembles and validates 14-byte UART
//          frames, applies channel config/enable, returns 6-byte status.
// Rev    : 1.0  initial release
// ============================================================================
module uart_pwm_cmd_ctrl #(
    parameter int         NUM_CH      = 3,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] HDR         = 8'h55,
    parameter logic [7:0] FTR         = 8'hAA
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [NUM_CH-1:0] cfg_wr,
    output logic [7:0]        cfg_duty,
    output logic [15:0]       cfg_dessert,
    output logic [7:0]        cfg_pulse_num,
    output logic [31:0]       cfg_pattern,
    output logic [NUM_CH-1:0] ch_en,
    output logic              busy
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RECV  = 3'd1;
    localparam logic [2:0] c_CHECK = 3'd2;
    localparam logic [2:0] c_APPLY = 3'd3;
    localparam logic [2:0] c_RESP  = 3'd4;

    localparam int                 c_GAP_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_GAP_W-1:0] c_TIMEOUT = c_GAP_W'(TIMEOUT_CYC);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [3:0]         r_idx;
    logic [c_GAP_W-1:0] r_gap;
    logic [7:0]         r_crc;
    logic [7:0]         r_frame [0:15];
    logic [7:0]         r_status;
    logic [7:0]         w_status;
    logic [2:0]         r_tx_idx;
    logic               r_tx_valid;
    logic [NUM_CH-1:0]  r_cfg_wr;
    logic [NUM_CH-1:0]  r_ch_en;
    logic [NUM_CH-1:0]  w_ch_hot;
    logic [7:0]         r_duty;
    logic [15:0]        r_dessert;
    logic [7:0]         r_pulse_num;
    logic [31:0]        r_pattern;
    logic               w_timeout;
    logic               w_rx_take;
    logic               w_tx_fire;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Timeout takes precedence over a byte arriving in the same cycle.
    assign w_timeout = (r_gap >= c_TIMEOUT);
    assign w_rx_take = rx_valid && !w_timeout;
    assign w_tx_fire = r_tx_valid && tx_ready;

    always_comb begin
        w_ch_hot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_hot[i] = (r_frame[2] == 8'(i + 1));
        end
    end

    always_comb begin
        w_status = 8'h00;
        if (r_frame[13] != FTR)                              w_status = 8'h04;
        else if (r_crc != r_frame[12])                       w_status = 8'h01;
        else if (r_frame[2] == 8'h00 || r_frame[2] > 8'(NUM_CH)) w_status = 8'h03;
        else if (r_frame[1] != 8'h01 && r_frame[1] != 8'h02) w_status = 8'h02;
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= c_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (rx_valid && rx_data == HDR) w_next_state = c_RECV;
            c_RECV: begin
                if (w_timeout)                         w_next_state = c_IDLE;
                else if (rx_valid && r_idx == 4'd13)   w_next_state = c_CHECK;
            end
            c_CHECK: w_next_state = c_APPLY;
            c_APPLY: w_next_state = c_RESP;
            c_RESP:  if (w_tx_fire && r_tx_idx == 3'd5) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (r_state != c_IDLE);
        tx_data = 8'h00;
        if (r_tx_valid) begin
            case (r_tx_idx)
                3'd0:    tx_data = 8'h5A;
                3'd1:    tx_data = r_frame[1];
                3'd2:    tx_data = r_frame[2];
                3'd3:    tx_data = r_status;
                3'd4:    tx_data = 8'(r_ch_en);
                3'd5:    tx_data = 8'hA5;
                default: tx_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_idx       <= 4'd0;
            r_gap       <= '0;
            r_crc       <= 8'h00;
            for (int i = 0; i < 16; i++) r_frame[i] <= 8'h00;
            r_status    <= 8'h00;
            r_tx_idx    <= 3'd0;
            r_tx_valid  <= 1'b0;
            r_cfg_wr    <= '0;
            r_ch_en     <= '0;
            r_duty      <= 8'h00;
            r_dessert   <= 16'h0000;
            r_pulse_num <= 8'h00;
            r_pattern   <= 32'h0;
        end else begin
            r_cfg_wr <= '0;
            case (r_state)
                c_IDLE: begin
                    if (rx_valid && rx_data == HDR) begin
                        r_idx <= 4'd1;
                        r_gap <= '0;
                        r_crc <= 8'h00;
                    end
                end
                c_RECV: begin
                    if (w_rx_take) begin
                        r_frame[r_idx] <= rx_data;
                        if (r_idx <= 4'd11) r_crc <= crc8_next(r_crc, rx_data);
                        r_idx <= r_idx + 4'd1;
                        r_gap <= '0;
                    end else if (!w_timeout) begin
                        r_gap <= r_gap + c_GAP_W'(1);
                    end
                end
                // Side effects land on the CHECK->APPLY edge so they are visible in APPLY.
                c_CHECK: begin
                    r_status   <= w_status;
                    r_tx_idx   <= 3'd0;
                    r_tx_valid <= 1'b1;
                    if (w_status == 8'h00) begin
                        if (r_frame[1] == 8'h01) begin
                            r_duty      <= r_frame[4];
                            r_dessert   <= {r_frame[5], r_frame[6]};
                            r_pulse_num <= r_frame[7];
                            r_pattern   <= {r_frame[8], r_frame[9], r_frame[10], r_frame[11]};
                            r_cfg_wr    <= w_ch_hot;
                        end else begin
                            r_ch_en <= (r_ch_en & ~w_ch_hot) | (w_ch_hot & {NUM_CH{r_frame[3][0]}});
                        end
                    end
                end
                c_APPLY, c_RESP: begin
                    if (w_tx_fire) begin
                        if (r_tx_idx == 3'd5) r_tx_valid <= 1'b0;
                        else                  r_tx_idx   <= r_tx_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_valid      = r_tx_valid;
    assign cfg_wr        = r_cfg_wr;
    assign cfg_duty      = r_duty;
    assign cfg_dessert   = r_dessert;
    assign cfg_pulse_num = r_pulse_num;
    assign cfg_pattern   = r_pattern;
    assign ch_en         = r_ch_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_pwm_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_pwm_cmd_ctrl
// Brief  : Directed + random frame bench with a frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_pwm_cmd_ctrl;

    localparam int TO = 200;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  cfg_wr;
    logic [7:0]  cfg_duty;
    logic [15:0] cfg_dessert;
    logic [7:0]  cfg_pulse_num;
    logic [31:0] cfg_pattern;
    logic [2:0]  ch_en;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int wr_pulses = 0;
    int tv_count  = 0;

    logic [2:0]  m_ch_en;
    logic [7:0]  m_duty;
    logic [15:0] m_des;
    logic [7:0]  m_pn;
    logic [31:0] m_pat;

    uart_pwm_cmd_ctrl #(
        .NUM_CH(3), .TIMEOUT_CYC(TO), .HDR(8'h55), .FTR(8'hAA)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cfg_wr(cfg_wr), .cfg_duty(cfg_duty), .cfg_dessert(cfg_dessert),
        .cfg_pulse_num(cfg_pulse_num), .cfg_pattern(cfg_pattern),
        .ch_en(ch_en), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (cfg_wr != 3'b000) wr_pulses++;
        if (tx_valid)         tv_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as polynomial remainder of msg*x^8 modulo x^8+x^2+x+1.
    function automatic logic [7:0] crc_model(input logic [87:0] msg);
        logic [95:0] r;
        r = {msg, 8'h00};
        for (int i = 95; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [111:0] build(input logic [7:0] fn, input logic [7:0] ch,
                                           input logic [7:0] ctl, input logic [7:0] duty,
                                           input logic [15:0] des, input logic [7:0] pn,
                                           input logic [31:0] pat, input logic [7:0] crcx,
                                           input logic [7:0] ftr);
        logic [87:0] msg;
        msg = {fn, ch, ctl, duty, des, pn, pat};
        return {8'h55, msg, crc_model(msg) ^ crcx, ftr};
    endfunction

    function automatic logic [7:0] model_status(input logic [111:0] f);
        if (f[7:0] != 8'hAA)                    return 8'h04;
        if (f[15:8] != crc_model(f[103:16]))    return 8'h01;
        if (f[95:88] == 8'd0 || f[95:88] > 8'd3) return 8'h03;
        if (f[103:96] != 8'd1 && f[103:96] != 8'd2) return 8'h02;
        return 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic run_frame(input logic [111:0] f, input bit bp, input int gap_at, input int gap_len);
        logic [7:0]  st, fn, ch;
        logic [2:0]  exp_wr;
        logic [47:0] rsp;
        int          wr0;
        fn = f[103:96];
        ch = f[95:88];
        st = model_status(f);
        exp_wr = 3'b000;
        if (st == 8'h00) begin
            if (fn == 8'h01) begin
                exp_wr = 3'b001 << (ch - 8'd1);
                m_duty = f[79:72];
                m_des  = f[71:56];
                m_pn   = f[55:48];
                m_pat  = f[47:16];
            end else begin
                m_ch_en[ch - 8'd1] = f[80];
            end
        end
        rsp = {8'h5A, fn, ch, st, 5'b00000, m_ch_en, 8'hA5};
        wr0 = wr_pulses;
        tx_ready = !bp;
        for (int i = 0; i < 14; i++) begin
            send_byte(f[111 - 8*i -: 8]);
            if (i == gap_at) repeat (gap_len) @(negedge sys_clk);
        end
        chk("check_busy", {31'd0, busy}, 32'd1);
        chk("check_txv", {31'd0, tx_valid}, 32'd0);
        chk("check_wr", {29'd0, cfg_wr}, 32'd0);
        @(negedge sys_clk);
        chk("apply_wr", {29'd0, cfg_wr}, {29'd0, exp_wr});
        chk("apply_chen", {29'd0, ch_en}, {29'd0, m_ch_en});
        chk("apply_duty", {24'd0, cfg_duty}, {24'd0, m_duty});
        chk("apply_des", {16'd0, cfg_dessert}, {16'd0, m_des});
        chk("apply_pn", {24'd0, cfg_pulse_num}, {24'd0, m_pn});
        chk("apply_pat", cfg_pattern, m_pat);
        for (int k = 0; k < 6; k++) begin
            if (bp) begin
                repeat (20) begin
                    chk("bp_txv", {31'd0, tx_valid}, 32'd1);
                    chk("bp_stable", {24'd0, tx_data}, {24'd0, rsp[47 - 8*k -: 8]});
                    @(negedge sys_clk);
                end
                tx_ready = 1'b1;
            end
            chk("rsp_txv", {31'd0, tx_valid}, 32'd1);
            chk("rsp_byte", {24'd0, tx_data}, {24'd0, rsp[47 - 8*k -: 8]});
            @(negedge sys_clk);
            if (bp) tx_ready = 1'b0;
        end
        chk("end_txv", {31'd0, tx_valid}, 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("wr_pulses", wr_pulses - wr0, (exp_wr != 3'b000) ? 32'd1 : 32'd0);
    endtask

    logic [111:0] fr;
    logic [7:0]   r_fn, r_ch, r_cx, r_ft;
    int           tv0, sel;

    initial begin
        sys_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        m_ch_en = 3'b000; m_duty = 8'h00; m_des = 16'h0; m_pn = 8'h00; m_pat = 32'h0;
        repeat (3) @(negedge sys_clk);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_txd", {24'd0, tx_data}, 32'd0);
        chk("rst_wr", {29'd0, cfg_wr}, 32'd0);
        chk("rst_duty", {24'd0, cfg_duty}, 32'd0);
        chk("rst_des", {16'd0, cfg_dessert}, 32'd0);
        chk("rst_pn", {24'd0, cfg_pulse_num}, 32'd0);
        chk("rst_pat", cfg_pattern, 32'd0);
        chk("rst_chen", {29'd0, ch_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        run_frame(build(8'h01, 8'h02, 8'h01, 8'h01, 16'h0002, 8'h00, 32'h3, 8'h00, 8'hAA), 1'b0, -1, 0);
        run_frame(build(8'h02, 8'h01, 8'h01, 8'h00, 16'h0, 8'h00, 32'h0, 8'h00, 8'hAA), 1'b0, -1, 0);
        run_frame(build(8'h02, 8'h03, 8'h01, 8'h00, 16'h0, 8'h00, 32'h0, 8'h00, 8'hAA), 1'b0, -1, 0);
        run_frame(build(8'h02, 8'h03, 8'h00, 8'h00, 16'h0, 8'h00, 32'h0, 8'h00, 8'hAA), 1'b0, -1, 0);
        run_frame(build(8'h02, 8'h01, 8'h00, 8'h00, 16'h0, 8'h00, 32'h0, 8'h01, 8'hAA), 1'b0, -1, 0);
        run_frame(build(8'h01, 8'h04, 8'h01, 8'h11, 16'h2233, 8'h44, 32'h55667788, 8'h00, 8'hAA), 1'b0, -1, 0);
        run_frame(build(8'h05, 8'h01, 8'h01, 8'h11, 16'h2233, 8'h44, 32'h55667788, 8'h00, 8'hAA), 1'b0, -1, 0);
        run_frame(build(8'h01, 8'h01, 8'h01, 8'h11, 16'h2233, 8'h44, 32'h55667788, 8'h3C, 8'hAB), 1'b0, -1, 0);

        // Noise before the header, then full backpressure on every response byte.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        run_frame(build(8'h01, 8'h01, 8'h00, 8'h9A, 16'hBEEF, 8'h07, 32'hCAFE0155, 8'h00, 8'hAA), 1'b1, -1, 0);

        // Inter-byte gap just under the timeout is tolerated.
        run_frame(build(8'h01, 8'h03, 8'h00, 8'h21, 16'h5555, 8'h55, 32'h12345678, 8'h00, 8'hAA), 1'b0, 5, TO - 2);

        // Truncated frame times out silently.
        fr = build(8'h02, 8'h02, 8'h01, 8'h00, 16'h0, 8'h00, 32'h0, 8'h00, 8'hAA);
        tv0 = tv_count;
        for (int i = 0; i < 7; i++) send_byte(fr[111 - 8*i -: 8]);
        repeat (TO - 2) @(negedge sys_clk);
        chk("to_busy_pre", {31'd0, busy}, 32'd1);
        repeat (7) @(negedge sys_clk);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_no_rsp", tv_count - tv0, 32'd0);
        chk("to_chen", {29'd0, ch_en}, {29'd0, m_ch_en});
        run_frame(fr, 1'b0, -1, 0);

        for (int n = 0; n < 12; n++) begin
            sel  = $urandom_range(0, 5);
            r_fn = (sel < 3) ? 8'h01 : (sel < 5) ? 8'h02 : 8'($urandom);
            r_ch = 8'($urandom_range(0, 4));
            r_cx = 8'h00;
            r_ft = 8'hAA;
            sel  = $urandom_range(0, 7);
            if (sel == 6) r_cx = 8'($urandom_range(1, 255));
            if (sel == 7) r_ft = 8'hAA ^ 8'($urandom_range(1, 255));
            fr = build(r_fn, r_ch, 8'($urandom), 8'($urandom), 16'($urandom), 8'($urandom),
                       32'($urandom), r_cx, r_ft);
            run_frame(fr, ($urandom_range(0, 3) == 0), -1, 0);
        end

        // Reset during response byte 3 aborts the response.
        run_frame(build(8'h02, 8'h02, 8'h01, 8'h00, 16'h0, 8'h00, 32'h0, 8'h00, 8'hAA), 1'b0, -1, 0);
        fr = build(8'h02, 8'h09, 8'h01, 8'h00, 16'h0, 8'h00, 32'h0, 8'h00, 8'hAA);
        tx_ready = 1'b0;
        for (int i = 0; i < 14; i++) send_byte(fr[111 - 8*i -: 8]);
        @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            tx_ready = 1'b1;
            @(negedge sys_clk);
            tx_ready = 1'b0;
        end
        chk("mid_rsp_byte3", {24'd0, tx_data}, {24'd0, model_status(fr)});
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("abort_txv", {31'd0, tx_valid}, 32'd0);
        chk("abort_txd", {24'd0, tx_data}, 32'd0);
        chk("abort_chen", {29'd0, ch_en}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_duty", {24'd0, cfg_duty}, 32'd0);
        sys_rst = 1'b0;
        tx_ready = 1'b1;
        m_ch_en = 3'b000; m_duty = 8'h00; m_des = 16'h0; m_pn = 8'h00; m_pat = 32'h0;
        tv0 = tv_count;
        repeat (10) @(negedge sys_clk);
        chk("abort_no_rsp", tv_count - tv0, 32'd0);
        run_frame(build(8'h02, 8'h01, 8'h01, 8'h00, 16'h0, 8'h00, 32'h0, 8'h00, 8'hAA), 1'b0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_pwm_cmd_ctrl.md
Name: uart_pwm_cmd_ctrl

Overview:
Command controller between the UART byte receiver and the PWM/DAC/slow-PWM channel generators in dds_sample_top.
- Assembles 14-byte host frames and validates header, footer and CRC.
- Dispatches configuration writes and enable/disable commands to channels 1..NUM_CH.
- Returns a 6-byte status response through the UART transmitter.

Parameters:
NUM_CH, 3, number of addressable channels (ch codes 1..NUM_CH)
TIMEOUT_CYC, 50000, max sys_clk cycles between bytes of one frame (1 ms at 50 MHz)
HDR, 8'h55, frame header byte
FTR, 8'hAA, frame footer byte

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  response byte
tx_valid  out  1  response byte valid, held until tx_ready
tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
cfg_wr  out  NUM_CH  one-hot, one-cycle config write strobe
cfg_duty  out  8  duty_num
cfg_dessert  out  16  pulse_dessert {H,L}
cfg_pulse_num  out  8  pulse_num
cfg_pattern  out  32  {pat1,pat2,pat3,pat4}, pat1 is MSB
ch_en  out  NUM_CH  registered channel enables
busy  out  1  high in any state except IDLE

Behaviour:
- Frame byte order: HDR, func, ch, ctrl_sta, duty, dessert_h, dessert_l, pulse_num, pat1..pat4, crc, FTR.
- CRC-8: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR. Covers bytes 1..11 (func..pat4).
- States: IDLE, RECV, CHECK, APPLY, RESP.
- IDLE: non-HDR bytes are ignored. HDR moves to RECV; byte index = 1, gap counter cleared, CRC cleared.
- RECV: on each rx_valid, store the byte, update CRC for indices 1..11, increment index, clear gap counter.
  - The byte at index 13 moves to CHECK.
  - Gap counter reaching TIMEOUT_CYC returns to IDLE: frame discarded, no response, no side effects.
  - A HDR value inside the frame is treated as data (no resync).
- CHECK (1 cycle): status in priority order:
  - 04 footer != FTR
  - 01 CRC mismatch
  - 03 ch == 0 or ch > NUM_CH
  - 02 func not in {01, 02}
  - 00 OK
- APPLY (1 cycle), only when status 00:
  - func 01: cfg_* registers load frame fields; cfg_wr[ch-1] pulses in this cycle.
  - func 02: ch_en[ch-1] <= ctrl_sta[0]; cfg_wr stays 0.
  - Any nonzero status: no cfg/ch_en change.
- Latency: FTR rx_valid at cycle T; CHECK at T+1; cfg_wr and ch_en change at T+2; tx_valid first asserted at T+2.
- RESP: sends 5A, func, ch, status, ch_en (zero-extended, value after APPLY), A5.
  - Byte advances only on tx_valid & tx_ready; tx_data stable while tx_valid && !tx_ready.
  - Returns to IDLE after the 6th handshake.
  - rx_valid during CHECK/APPLY/RESP is discarded.
- Reset values: tx_valid 0, tx_data 00, cfg_wr 0, cfg_duty 00, cfg_dessert 0000, cfg_pulse_num 00, cfg_pattern 0, ch_en 0, busy 0, state IDLE.
- Reset asserted mid-frame or mid-response aborts immediately to reset values; no partial response continues.
- rx_valid coinciding with timeout expiry: the timeout wins and the byte is dropped.
- cfg_* buses hold their last written value; a write for one channel does not affect other channels' enables.

Test Plan:
- Write: 55 01 02 01 01 00 02 00 00 00 00 03 crc AA (crc from bench CRC-8 model), tx_ready=1 -> cfg_wr=3'b010 for one cycle at T+2, cfg_duty=01, cfg_dessert=0002, cfg_pattern=00000003; response 5A 01 02 00 00 A5.
- Enable: 55 02 01 01 00.. crc AA -> ch_en=001; response 5A 02 01 00 01 A5. Then 55 02 03 01 .. -> ch_en=101. Then ch3 with ctrl_sta 00 -> ch_en=001.
- CRC error: enable-off frame for ch1 with crc^01 -> ch_en unchanged (001), no cfg_wr; response 5A 02 01 01 01 A5.
- Bad fields: ch=04 -> status 03; func=05 with ch=1 -> status 02; footer 0xAB -> status 04 even with bad CRC; no state change in all three.
- Backpressure/noise: garbage bytes 00 FF 12 before header -> ignored, frame still accepted. Hold tx_ready=0 for 20 cycles on each byte -> tx_data stable, all 6 bytes delivered in order.
- Timeout/reset: stop after 7 bytes, wait TIMEOUT_CYC+1 -> IDLE, busy=0, no response; next full frame works. Assert sys_rst during response byte 3 -> tx_valid=0 next cycle, ch_en=0.
